atm_txn_ctrl: RTL
=================

// Module: atm_txn_ctrl
// PURPOSE
//  Transaction sequencer that owns the ATM account balance register. It accepts one
//  deposit or withdraw request at a time from the ATM menu FSM, checks it, commits it
//  and returns a status code. On any rejection it holds a warning window before
//  accepting the next request. The menu FSM stops writing the balance itself and issues
//  requests here instead.
// PARAMETERS
//  BAL_W        16   balance width, unsigned
//  AMT_W        4    request amount width, unsigned (matches SW[3:0])
//  HOLD_CYCLES  250  warning-hold length in clk cycles after a reject; 0 = no hold
//  WD_LIMIT     20   cumulative withdraw limit per session (used only with ATM_WD_LIMIT_EN)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      ready to accept; 1 only in IDLE
//  req_op       in   1      0 = deposit, 1 = withdraw
//  req_amount   in   AMT_W  amount
//  session_clr  in   1      end of card session; clears the withdraw tally
//  rsp_valid    out  1      one-cycle response strobe
//  rsp_code     out  2      00 OK, 01 NSF (insufficient), 10 OVF (overflow), 11 LIMIT
//  balance      out  BAL_W  committed balance
//  warn         out  1      high during the warning hold
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (rst==0 sampled at posedge clk):
//   - State goes to IDLE.
//   - balance=0, rsp_valid=0, rsp_code=00, warn=0, tally=0, hold counter=0.
//   - Reset overrides any operation in flight; no response is issued for it.
//  Handshake: accept occurs when req_valid && req_ready at a posedge; op/amount latched.
//  FSM states:
//   - IDLE: ready=1; on accept -> EXEC.
//   - EXEC: evaluate the latched request. Priority OVF > NSF > LIMIT:
//       deposit: balance+amount > 2^BAL_W-1 -> OVF, else OK
//       withdraw: amount > balance -> NSF; else LIMIT check (macro); else OK
//     On OK, balance is updated at the EXEC->RESP edge. -> RESP.
//   - RESP: rsp_valid=1 for exactly one cycle with rsp_code.
//     code==OK or HOLD_CYCLES==0 -> IDLE; else -> HOLD.
//   - HOLD: warn=1 for exactly HOLD_CYCLES cycles, then -> IDLE.
//  Latency:
//   - Accept edge k: EXEC in cycle k+1; RESP (rsp_valid, new balance) in cycle k+2.
//   - Back-to-back OK requests: one per 3 cycles.
//  Arithmetic: amount zero-extended to BAL_W. Overflow checked on a BAL_W+1 sum.
//   Balance never wraps; rejected requests leave balance unchanged.
//  Boundaries:
//   - amount==0 -> OK, no change.
//   - withdraw amount==balance -> OK, balance=0.
//   - deposit to exactly 2^BAL_W-1 -> OK.
//  session_clr: takes effect in any state. Clears the tally the same cycle.
//   Simultaneous with an OK withdraw commit: clear wins, tally=0.
//  req_valid outside IDLE is ignored (not queued).
// CONFIGURATION
//  ATM_WD_LIMIT_EN defined:
//   - BAL_W-bit tally accumulates amounts of OK withdraws.
//   - A withdraw with tally+amount > WD_LIMIT returns LIMIT with no change.
//  ATM_WD_LIMIT_EN undefined:
//   - No tally; code 11 is never produced.
//   - WD_LIMIT and session_clr are ignored.
// STRUCTURE
//  Package atm_pkg: op encoding (OP_DEP/OP_WD), rsp codes (RSP_OK/NSF/OVF/LIMIT),
//   and the state encoding (IDLE/EXEC/RESP/HOLD).
//  Sub-module atm_hold_timer: loadable down-counter of width $clog2(HOLD_CYCLES+1).
//   Ports: start, done, active.
// TESTING
//  1. Reset, deposit 9 then deposit 7 -> two OK; balance=16; rsp_valid at k+2 each.
//  2. balance=5, withdraw 6 -> NSF, balance 5, warn high exactly HOLD_CYCLES,
//     req_ready=0 throughout.
//  3. balance=16'hFFF8, deposit 7 -> OK FFFF; deposit 1 -> OVF, FFFF kept.
//  4. balance=3, withdraw 3 -> OK 0; withdraw 0 -> OK 0; req_valid held in EXEC ignored.
//  5. Macro on, WD_LIMIT=20, balance 40:
//     - withdraw 15 -> OK; withdraw 6 -> LIMIT.
//     - session_clr, then withdraw 6 -> OK, balance 19.
//  6. rst low during EXEC of withdraw 4 -> no rsp_valid, balance=0, IDLE next cycle.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM transaction sequencer: request ops, response codes, FSM states.
package atm_pkg;

    typedef enum logic {
        OP_DEP = 1'b0,
        OP_WD  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK    = 2'b00,
        RSP_NSF   = 2'b01,
        RSP_OVF   = 2'b10,
        RSP_LIMIT = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

endpackage

// File: rtl/atm_hold_timer.sv
// Loadable down-counter timing the post-reject warning window.
module atm_hold_timer #(
    parameter int HOLD_CYCLES = 250,
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done,
    output logic active
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(HOLD_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // done marks the last cycle of the window so the FSM leaves HOLD on that edge
    assign done   = (cnt_q == CNT_W'(1));
    assign active = (cnt_q != '0);

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM balance owner: accepts one deposit/withdraw at a time, validates, commits, responds.
// Optional per-session withdraw limit enabled by defining ATM_WD_LIMIT_EN.
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter int BAL_W       = 16,
    parameter int AMT_W       = 4,
    parameter int HOLD_CYCLES = 250,
    parameter int WD_LIMIT    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             session_clr,
    output logic             rsp_valid,
    output logic [1:0]       rsp_code,
    output logic [BAL_W-1:0] balance,
    output logic             warn,
    output logic             busy
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [BAL_W-1:0] bal_q, bal_d;
    rsp_e             rsp_code_q, rsp_code_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             warn_q, warn_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W:0]   dep_sum;
    rsp_e             code_eval;
    logic             hold_start, hold_done, hold_active;

    assign amt_ext = BAL_W'(amt_q);
    assign dep_sum = {1'b0, bal_q} + {1'b0, amt_ext};

`ifdef ATM_WD_LIMIT_EN
    logic [BAL_W-1:0] tally_q, tally_d;
    logic [BAL_W:0]   tally_sum;
    assign tally_sum = {1'b0, tally_q} + {1'b0, amt_ext};
`else
    logic             unused_sess_clr;
    logic [BAL_W-1:0] unused_wd_limit;
    assign unused_sess_clr = session_clr;
    assign unused_wd_limit = BAL_W'(WD_LIMIT);
`endif

    // Reject priority: overflow, then insufficient funds, then session limit
    always_comb begin
        code_eval = RSP_OK;
        if (op_q == OP_DEP) begin
            if (dep_sum[BAL_W]) code_eval = RSP_OVF;
        end else if (amt_ext > bal_q) begin
            code_eval = RSP_NSF;
        end
`ifdef ATM_WD_LIMIT_EN
        else if (tally_sum > (BAL_W+1)'(WD_LIMIT)) begin
            code_eval = RSP_LIMIT;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        amt_d       = amt_q;
        bal_d       = bal_q;
        rsp_code_d  = rsp_code_q;
        rsp_valid_d = 1'b0;
`ifdef ATM_WD_LIMIT_EN
        tally_d     = tally_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    amt_d   = req_amount;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_code_d  = code_eval;
                rsp_valid_d = 1'b1;
                if (code_eval == RSP_OK) begin
                    if (op_q == OP_DEP) begin
                        bal_d = dep_sum[BAL_W-1:0];
                    end else begin
                        bal_d = bal_q - amt_ext;
`ifdef ATM_WD_LIMIT_EN
                        tally_d = tally_sum[BAL_W-1:0];
`endif
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_code_q == RSP_OK || HOLD_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done || !hold_active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef ATM_WD_LIMIT_EN
        // End of session beats a same-cycle withdraw commit
        if (session_clr) tally_d = '0;
`endif
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        warn_d  = (state_d == ST_HOLD);
    end

    assign hold_start = (state_q == ST_RESP) && (state_d == ST_HOLD);

    atm_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (hold_start),
        .done   (hold_done),
        .active (hold_active)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_DEP;
            amt_q       <= '0;
            bal_q       <= '0;
            rsp_code_q  <= RSP_OK;
            rsp_valid_q <= 1'b0;
            warn_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ATM_WD_LIMIT_EN
            tally_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            bal_q       <= bal_d;
            rsp_code_q  <= rsp_code_d;
            rsp_valid_q <= rsp_valid_d;
            warn_q      <= warn_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
`ifdef ATM_WD_LIMIT_EN
            tally_q     <= tally_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign balance   = bal_q;
    assign warn      = warn_q;
    assign busy      = busy_q;

endmodule
